// File: rtl/jtag_gpr_access_if.sv
// jtag_gpr_access_if: debug-module command/response handshake bus for GPR access
interface jtag_gpr_access_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/jtag_gpr_access.sv
// jtag_gpr_access: sequences debug GPR read/write commands onto the register file's JTAG port
module jtag_gpr_access #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  jtag_gpr_access_if.slave  dbg,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  output logic              jtag_we_o,
  output logic [ADDR_W-1:0] jtag_addr_o,
  output logic [DATA_W-1:0] jtag_data_o,
  input  logic [DATA_W-1:0] jtag_data_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
  logic              rdy_q, rdy_d, rv_q, rv_d, rerr_q, rerr_d;
  logic              wr_blocks, rd_blocks, blocked, tmo;
  // Next-state logic: a core write to any real register steals the write port; a read only
  // waits while the core is updating the very register being sampled (no bypass reliance).
  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    tmo       = cnt_inc == CW'(TIMEOUT);
    wr_blocks = ex_we_i && ex_waddr_i != '0 && addr_q != '0;
    rd_blocks = ex_we_i && ex_waddr_i == addr_q && addr_q != '0;
    blocked   = state_q == WRITE ? wr_blocks : rd_blocks;
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    rv_d      = rv_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    case (state_q)
      IDLE: if (dbg.req_valid) begin
        state_d = dbg.req_write ? WRITE : READ;
        addr_d  = dbg.req_addr;
        data_d  = dbg.req_data;
        cnt_d   = '0;
        rdy_d   = 1'b0;
      end
      WRITE, READ: begin
        cnt_d = blocked ? cnt_inc : cnt_q;
        if (!blocked || tmo) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rerr_d  = blocked;
          rdata_d = (state_q == READ && !blocked && addr_q != '0) ? jtag_data_i : '0;
        end
      end
      default: if (dbg.resp_ready) begin
        state_d = IDLE;
        rv_d    = 1'b0;
        rdy_d   = 1'b1;
        rdata_d = '0;
        rerr_d  = 1'b0;
      end
    endcase
  end
  // State and registered outputs; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b1;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end
  assign jtag_we_o      = state_q == WRITE && !wr_blocks;
  assign jtag_addr_o    = addr_q;
  assign jtag_data_o    = data_q;
  assign dbg.req_ready  = rdy_q;
  assign dbg.resp_valid = rv_q;
  assign dbg.resp_data  = rdata_q;
  assign dbg.resp_err   = rerr_q;
endmodule

// File: doc/jtag_gpr_access.md
Name: jtag_gpr_access

Overview:
- Debug-side sequencer that owns the general-purpose register file's JTAG port (jtag_we / jtag_addr / jtag_data in, read data out).
- Converts single GPR read/write commands from the JTAG debug module into correctly timed register-file accesses.
- The core's write port has priority, so a JTAG write issued in the same cycle as an ex write would be silently dropped. This block monitors the ex write port, holds the access until it can land, and returns one response per command.

Parameters:
- ADDR_W, 5, GPR address width (32 registers).
- DATA_W, 32, GPR data width.
- TIMEOUT, 16, maximum blocked cycles per command before it is aborted with an error; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when both valid and ready are high.
- req_write_i  in  1  1 = write GPR, 0 = read GPR.
- req_addr_i  in  ADDR_W  GPR index.
- req_data_i  in  DATA_W  write data.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when both valid and ready are high.
- resp_data_o  out  DATA_W  read data; 0 for writes and for errors.
- resp_err_o  out  1  command aborted on timeout.
- ex_we_i  in  1  core register-file write enable (monitor only).
- ex_waddr_i  in  ADDR_W  core register-file write address (monitor only).
- jtag_we_o  out  1  register-file JTAG write strobe.
- jtag_addr_o  out  ADDR_W  register-file JTAG address.
- jtag_data_o  out  DATA_W  register-file JTAG write data.
- jtag_data_i  in  DATA_W  register-file JTAG read data (combinational from the register file).

Behaviour:
- Reset: state IDLE; blocked counter 0; all latched address/data 0.
- Output reset values: req_ready_o=1, resp_valid_o=0, resp_data_o=0, resp_err_o=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0.
- Reset asserted mid-command: the command is discarded, no strobe is issued and no response is produced.
- States:
  - IDLE: req_ready_o=1. On acceptance, latch write/addr/data, clear the counter, go to WRITE or READ.
  - WRITE:
    - ex_blocks = ex_we_i && (ex_waddr_i != 0).
    - jtag_we_o = !ex_blocks (combinational).
    - If !ex_blocks → RESP, data 0, err 0.
    - Else increment the counter. If counter+1 == TIMEOUT → RESP, err 1.
  - READ:
    - rd_blocks = ex_we_i && (ex_waddr_i == addr) && (addr != 0).
    - If !rd_blocks, capture jtag_data_i → RESP, err 0.
    - Else increment the counter; timeout as in WRITE (resp_data 0, err 1).
  - RESP: resp_valid_o=1, data/err held stable until resp_ready_i; then → IDLE.
- jtag_addr_o and jtag_data_o are driven from the latched registers and held from acceptance through RESP. jtag_we_o is 0 in every state except unblocked WRITE.
- Address 0:
  - Write completes in WRITE on its first cycle. The strobe may assert (the register file ignores x0); the response is data 0, err 0.
  - Read returns 0.
- Timing with no blocking (acceptance at cycle N):
  - Write strobe at N+1, resp_valid_o at N+2.
  - Read sample at N+1, resp_valid_o at N+2.
- Each blocked cycle adds one cycle of latency.
- One command outstanding at a time. req_ready_o=0 from acceptance until the response handshake completes; no new command is accepted in the same cycle as the response handshake.
- The counter saturates logic at TIMEOUT (abort). With TIMEOUT=1, the first blocked cycle aborts.
- Read data is always the committed register value at the sample cycle (the register file's write-bypass is never relied on).

Test Plan:
- Write x5=0xDEADBEEF with ex idle → jtag_we_o=1, jtag_addr_o=5, jtag_data_o=0xDEADBEEF exactly at N+1. resp_valid at N+2, err 0. A subsequent read of x5 returns 0xDEADBEEF.
- Write x7=0x1234 while ex_we_i=1, ex_waddr_i=3 for 3 cycles → jtag_we_o=0 for those 3 cycles, strobe on the 4th cycle, resp_valid 1 cycle later, err 0.
- Write x9 with ex_we_i=1, ex_waddr_i=9 held for 20 cycles, TIMEOUT=16 → no strobe ever. resp_valid after 16 blocked cycles with err=1, data 0.
- Read x4 (holding 0x55) while ex writes x4=0xAA for 2 cycles → the sample is deferred and resp_data=0xAA. A read of x0 returns 0 with err 0.
- Hold resp_ready_i=0 for 5 cycles → resp_valid_o, resp_data_o and resp_err_o remain stable and req_ready_o=0. The next command is accepted only after the handshake completes.
- Assert rst during a blocked WRITE → all outputs go to reset values immediately. No strobe and no response after release; req_ready_o=1.
